// File: rtl/mini_core_pkg.sv
// mini_core_pkg: shared core-to-memory request type and memory arbiter tag types
package mini_core_pkg;
  localparam int STARVE_CNT_W = 3;
  typedef struct packed {
    logic        rd_en;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [3:0]  byte_en;
  } t_core2mem_req;
  typedef enum logic {OWN_FETCH, OWN_DATA} t_mem_owner;
  typedef struct packed {
    logic       valid;
    t_mem_owner owner;
  } t_mem_tag;
endpackage

// File: rtl/mini_core_mem_arb_tagq.sv
// mini_core_mem_arb_tagq: DEPTH-stage read tag shift register with synchronous flush
module mini_core_mem_arb_tagq
  import mini_core_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  t_mem_tag push,
  output t_mem_tag pop
);
  t_mem_tag pipe_q [DEPTH];
  t_mem_tag pipe_d [DEPTH];
  // shift every cycle; the newest tag enters stage 0
  always_comb begin
    pipe_d[0] = push;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end
  // flush drops every in-flight tag
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) pipe_q[i] <= rst ? '0 : pipe_d[i];
  end
  assign pop = pipe_q[DEPTH-1];
endmodule

// File: rtl/mini_core_mem_arb.sv
// mini_core_mem_arb: fetch/data arbiter for the unified memory; MINI_CORE_MEM_ARB_RR_EN selects round-robin conflicts
module mini_core_mem_arb
  import mini_core_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic          Clock,
  input  logic          Rst,
  input  logic          FetchReq,
  input  logic [31:0]   FetchAddr,
  output logic          FetchGnt,
  output logic          FetchRspValid,
  output logic [31:0]   FetchRspData,
  input  t_core2mem_req DataReq,
  output logic          DataGnt,
  output logic          DataRspValid,
  output logic [31:0]   DataRspData,
  output logic          MemReqValid,
  output logic          MemReqWr,
  output logic [31:0]   MemReqAddr,
  output logic [31:0]   MemReqWrData,
  output logic [3:0]    MemReqByteEn,
  input  logic [31:0]   MemRdData
);
  logic     data_req;
  logic     conflict;
  logic     fetch_pick;
  t_mem_tag push_tag;
  t_mem_tag rsp_tag;
`ifdef MINI_CORE_MEM_ARB_RR_EN
  t_mem_owner last_winner_q, last_winner_d;
  assign fetch_pick = last_winner_q == OWN_DATA;
  // remember the conflict winner so the other side wins the next conflict
  always_comb last_winner_d = conflict && !Rst ? (FetchGnt ? OWN_FETCH : OWN_DATA) : last_winner_q;
  // round-robin state
  always_ff @(posedge Clock) begin
    if (Rst) last_winner_q <= OWN_FETCH;
    else last_winner_q <= last_winner_d;
  end
`else
  logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  assign fetch_pick = starve_cnt_q == STARVE_CNT_W'(STARVE_MAX);
  // count consecutive lost conflicts, saturating; any fetch grant or idle fetch restarts it
  always_comb starve_cnt_d = (!FetchReq || FetchGnt) ? '0 :
                             (conflict && starve_cnt_q != '1) ? starve_cnt_q + 1'b1 : starve_cnt_q;
  // starvation counter
  always_ff @(posedge Clock) begin
    if (Rst) starve_cnt_q <= '0;
    else starve_cnt_q <= starve_cnt_d;
  end
`endif
  // grant one requester per cycle and drive the memory port from the winner
  always_comb begin
    data_req       = DataReq.rd_en | DataReq.wr_en;
    conflict       = FetchReq & data_req;
    FetchGnt       = !Rst & FetchReq & (!data_req | fetch_pick);
    DataGnt        = !Rst & data_req & !FetchGnt;
    MemReqValid    = FetchGnt | DataGnt;
    MemReqWr       = DataGnt & DataReq.wr_en;
    MemReqAddr     = FetchGnt ? FetchAddr : DataGnt ? DataReq.addr : '0;
    MemReqWrData   = MemReqWr ? DataReq.wr_data : '0;
    MemReqByteEn   = MemReqWr ? DataReq.byte_en : MemReqValid ? 4'hF : 4'h0;
    push_tag.valid = MemReqValid & !MemReqWr;
    push_tag.owner = FetchGnt ? OWN_FETCH : OWN_DATA;
  end
  mini_core_mem_arb_tagq #(.DEPTH(RD_LAT)) u_tagq (
    .clk  (Clock),
    .rst  (Rst),
    .push (push_tag),
    .pop  (rsp_tag)
  );
  // route returning read data to the owner recorded at issue
  always_comb begin
    FetchRspValid = !Rst & rsp_tag.valid & (rsp_tag.owner == OWN_FETCH);
    DataRspValid  = !Rst & rsp_tag.valid & (rsp_tag.owner == OWN_DATA);
    FetchRspData  = FetchRspValid ? MemRdData : '0;
    DataRspData   = DataRspValid ? MemRdData : '0;
  end
endmodule
